// File: rtl/op_bus_cycle_pkg.sv
// rtl/op_bus_cycle_pkg.sv - shared encodings for the CPU bus machine-cycle engine
package op_bus_cycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        KIND_M1 = 2'd0,
        KIND_RD = 2'd1,
        KIND_WR = 2'd2
    } kind_t;

    localparam int XPT_MAX = 31;

    // Fixed priority among simultaneous requests: opcode fetch, then read, then write.
    function automatic kind_t pick_kind(input logic m1, input logic rd);
        if (m1) begin
            return KIND_M1;
        end else if (rd) begin
            return KIND_RD;
        end else begin
            return KIND_WR;
        end
    endfunction

endpackage

// File: rtl/op_bus_xpt_counter.sv
// rtl/op_bus_xpt_counter.sv - per-instruction phase counter with clear, increment and saturation
module op_bus_xpt_counter
    import op_bus_cycle_pkg::*;
#(
    parameter int XPT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [XPT_W-1:0] xpt,
    output logic [XPT_W-1:0] not_xpt
);

    localparam logic [XPT_W-1:0] XPT_SAT = XPT_W'(XPT_MAX);

    // Clear wins over increment; the count sticks once it reaches its ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpt <= '0;
        end else if (clear) begin
            xpt <= '0;
        end else if (inc && (xpt != XPT_SAT)) begin
            xpt <= xpt + 1'b1;
        end
    end

    assign not_xpt = ~xpt;

endmodule

// File: rtl/op_bus_cycle.sv
// rtl/op_bus_cycle.sv - M1 fetch / memory read / memory write bus cycle sequencer
module op_bus_cycle
    import op_bus_cycle_pkg::*;
#(
    parameter int XPT_W = 5,
    parameter int R_W   = 7
) (
    input  logic             CLK,
    input  logic             notRESET,
    input  logic             req_m1,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [15:0]      addr_in,
    input  logic [7:0]       wdata_in,
    input  logic             PR_Reset_XPT,
    input  logic             notWAIT,
    input  logic [7:0]       D_in,
    output logic [15:0]      A,
    output logic [7:0]       D_out,
    output logic             D_oe,
    output logic             notM1,
    output logic             notMREQ,
    output logic             notRD,
    output logic             notWR,
    output logic             notRFSH,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT
);

    state_t           state;
    state_t           next_state;
    kind_t            kind;
    kind_t            next_kind;
    logic             accept;
    logic             any_req;
    logic [15:0]      addr_q;
    logic [15:0]      next_addr;
    logic [7:0]       wdata_q;
    logic [7:0]       next_wdata;
    logic [R_W-1:0]   r_q;
    logic [15:0]      refresh_addr;
    logic             capture_rd;

    // Values the registered outputs take on the coming edge
    logic [15:0]      nx_a;
    logic [7:0]       nx_dout;
    logic             nx_oe;
    logic             nx_m1;
    logic             nx_mreq;
    logic             nx_rd;
    logic             nx_wr;
    logic             nx_rfsh;
    logic             nx_done;

    assign any_req      = req_m1 | req_rd | req_wr;
    assign refresh_addr = {{(16-R_W){1'b0}}, r_q};

    // Read data is latched while the bus still holds it: end of T2/TW for M1, end of T3 for reads.
    assign capture_rd = ((kind == KIND_M1) && ((state == ST_T2) || (state == ST_TW)) &&
                         (next_state == ST_T3)) ||
                        ((kind == KIND_RD) && (state == ST_T3));

    // State, cycle kind and captured request fields
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state   <= ST_IDLE;
            kind    <= KIND_M1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= next_state;
            kind    <= next_kind;
            addr_q  <= next_addr;
            wdata_q <= next_wdata;
        end
    end

    // T-state sequencing; a new request may start straight from the final T-state
    always_comb begin
        next_state = state;
        next_kind  = kind;
        accept     = 1'b0;
        case (state)
            ST_IDLE: next_state = ST_IDLE;
            ST_T1:   next_state = ST_T2;
            ST_T2:   next_state = notWAIT ? ST_T3 : ST_TW;
            ST_TW:   next_state = notWAIT ? ST_T3 : ST_TW;
            ST_T3:   next_state = (kind == KIND_M1) ? ST_T4 : ST_IDLE;
            ST_T4:   next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        if (((state == ST_IDLE) || done) && any_req) begin
            accept     = 1'b1;
            next_state = ST_T1;
            next_kind  = pick_kind(req_m1, req_rd);
        end
        next_addr  = accept ? addr_in : addr_q;
        next_wdata = accept ? wdata_in : wdata_q;
    end

    // Bus strobe, address and data values for the state being entered
    always_comb begin
        nx_a    = A;
        nx_dout = D_out;
        nx_oe   = 1'b0;
        nx_m1   = 1'b1;
        nx_mreq = 1'b1;
        nx_rd   = 1'b1;
        nx_wr   = 1'b1;
        nx_rfsh = 1'b1;
        nx_done = 1'b0;
        case (next_state)
            ST_T1, ST_T2, ST_TW: begin
                nx_a    = next_addr;
                nx_mreq = 1'b0;
                case (next_kind)
                    KIND_M1: begin
                        nx_m1 = 1'b0;
                        nx_rd = 1'b0;
                    end
                    KIND_RD: nx_rd = 1'b0;
                    default: begin
                        nx_oe   = 1'b1;
                        nx_dout = next_wdata;
                        nx_wr   = (next_state == ST_T1);
                    end
                endcase
            end
            ST_T3: begin
                nx_mreq = 1'b0;
                case (next_kind)
                    KIND_M1: begin
                        nx_a    = refresh_addr;
                        nx_rfsh = 1'b0;
                    end
                    KIND_RD: begin
                        nx_a    = next_addr;
                        nx_rd   = 1'b0;
                        nx_done = 1'b1;
                    end
                    default: begin
                        nx_a    = next_addr;
                        nx_oe   = 1'b1;
                        nx_dout = next_wdata;
                        nx_wr   = 1'b0;
                        nx_done = 1'b1;
                    end
                endcase
            end
            ST_T4: begin
                nx_a    = refresh_addr;
                nx_rfsh = 1'b0;
                nx_done = 1'b1;
            end
            default: begin
                nx_a = A;
            end
        endcase
    end

    // Registered bus outputs, read data and refresh counter
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            A       <= '0;
            D_out   <= '0;
            D_oe    <= 1'b0;
            notM1   <= 1'b1;
            notMREQ <= 1'b1;
            notRD   <= 1'b1;
            notWR   <= 1'b1;
            notRFSH <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
            r_q     <= '0;
        end else begin
            A       <= nx_a;
            D_out   <= nx_dout;
            D_oe    <= nx_oe;
            notM1   <= nx_m1;
            notMREQ <= nx_mreq;
            notRD   <= nx_rd;
            notWR   <= nx_wr;
            notRFSH <= nx_rfsh;
            busy    <= (next_state != ST_IDLE);
            done    <= nx_done;
            if (capture_rd) begin
                rd_data <= D_in;
            end
            if (state == ST_T4) begin
                r_q <= r_q + 1'b1;
            end
        end
    end

    op_bus_xpt_counter #(
        .XPT_W (XPT_W)
    ) u_xpt (
        .clk     (CLK),
        .rst_n   (notRESET),
        .clear   (PR_Reset_XPT),
        .inc     (done),
        .xpt     (XPT),
        .not_xpt (notXPT)
    );

endmodule

// File: tb/tb_op_bus_cycle.sv
// tb/tb_op_bus_cycle.sv - directed self-checking bench for op_bus_cycle
module tb_op_bus_cycle;

    logic        CLK = 1'b0;
    logic        notRESET;
    logic        req_m1, req_rd, req_wr;
    logic [15:0] addr_in;
    logic [7:0]  wdata_in;
    logic        PR_Reset_XPT;
    logic        notWAIT;
    logic [7:0]  D_in;
    logic [15:0] A;
    logic [7:0]  D_out;
    logic        D_oe;
    logic        notM1, notMREQ, notRD, notWR, notRFSH;
    logic        busy, done;
    logic [7:0]  rd_data;
    logic [4:0]  XPT, notXPT;

    int n_checks = 0;
    int n_fail   = 0;

    // flag byte: {notM1,notMREQ,notRD,notWR,notRFSH,D_oe,busy,done}
    localparam logic [7:0] F_IDLE  = 8'b11111000;
    localparam logic [7:0] F_M1_AB = 8'b00011010;
    localparam logic [7:0] F_M1_T3 = 8'b10110010;
    localparam logic [7:0] F_M1_T4 = 8'b11110011;
    localparam logic [7:0] F_RD    = 8'b10011010;
    localparam logic [7:0] F_RD_T3 = 8'b10011011;
    localparam logic [7:0] F_WR_T1 = 8'b10111110;
    localparam logic [7:0] F_WR_T2 = 8'b10101110;
    localparam logic [7:0] F_WR_T3 = 8'b10101111;

    op_bus_cycle dut (
        .CLK          (CLK),
        .notRESET     (notRESET),
        .req_m1       (req_m1),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .PR_Reset_XPT (PR_Reset_XPT),
        .notWAIT      (notWAIT),
        .D_in         (D_in),
        .A            (A),
        .D_out        (D_out),
        .D_oe         (D_oe),
        .notM1        (notM1),
        .notMREQ      (notMREQ),
        .notRD        (notRD),
        .notWR        (notWR),
        .notRFSH      (notRFSH),
        .busy         (busy),
        .done         (done),
        .rd_data      (rd_data),
        .XPT          (XPT),
        .notXPT       (notXPT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] flags();
        return {notM1, notMREQ, notRD, notWR, notRFSH, D_oe, busy, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        notRESET     = 1'b0;
        req_m1       = 1'b0;
        req_rd       = 1'b0;
        req_wr       = 1'b0;
        addr_in      = '0;
        wdata_in     = '0;
        PR_Reset_XPT = 1'b0;
        notWAIT      = 1'b1;
        D_in         = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_flags", flags(), F_IDLE);
        check("rst_a", A, 16'h0000);
        check("rst_dout", D_out, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_xpt", XPT, 5'd0);
        check("rst_notxpt", notXPT, 5'h1f);
        notRESET = 1'b1;
        tick();
        check("idle_flags", flags(), F_IDLE);

        // M1 fetch, no wait
        req_m1 = 1'b1; addr_in = 16'h1234; D_in = 8'hDD;
        tick(); req_m1 = 1'b0;
        check("m1_t1_flags", flags(), F_M1_AB);
        check("m1_t1_a", A, 16'h1234);
        tick();
        check("m1_t2_flags", flags(), F_M1_AB);
        tick();
        check("m1_t3_flags", flags(), F_M1_T3);
        check("m1_t3_a", A, 16'h0000);
        check("m1_rd_data", rd_data, 8'hDD);
        tick();
        check("m1_t4_flags", flags(), F_M1_T4);
        check("m1_t4_a", A, 16'h0000);
        check("m1_t4_xpt", XPT, 5'd0);
        tick();
        check("m1_end_flags", flags(), F_IDLE);
        check("m1_end_xpt", XPT, 5'd1);
        check("m1_end_notxpt", notXPT, 5'h1e);

        // Read with two wait states
        req_rd = 1'b1; addr_in = 16'hFFFE; D_in = 8'h5A;
        tick(); req_rd = 1'b0;
        check("rd_t1_flags", flags(), F_RD);
        check("rd_t1_a", A, 16'hFFFE);
        tick();
        check("rd_t2_flags", flags(), F_RD);
        notWAIT = 1'b0;
        tick();
        check("rd_tw1_flags", flags(), F_RD);
        tick();
        check("rd_tw2_flags", flags(), F_RD);
        notWAIT = 1'b1;
        tick();
        check("rd_t3_flags", flags(), F_RD_T3);
        check("rd_t3_rd_data", rd_data, 8'hDD);
        tick();
        check("rd_end_flags", flags(), F_IDLE);
        check("rd_end_rd_data", rd_data, 8'h5A);
        check("rd_end_xpt", XPT, 5'd2);

        // Back-to-back writes
        req_wr = 1'b1; addr_in = 16'h8000; wdata_in = 8'hA5;
        tick(); addr_in = 16'h8001; wdata_in = 8'h3C;
        check("wr1_t1_flags", flags(), F_WR_T1);
        check("wr1_t1_a", A, 16'h8000);
        check("wr1_t1_dout", D_out, 8'hA5);
        tick();
        check("wr1_t2_flags", flags(), F_WR_T2);
        check("wr1_t2_a", A, 16'h8000);
        check("wr1_t2_dout", D_out, 8'hA5);
        tick();
        check("wr1_t3_flags", flags(), F_WR_T3);
        tick(); req_wr = 1'b0;
        check("wr2_t1_flags", flags(), F_WR_T1);
        check("wr2_t1_a", A, 16'h8001);
        check("wr2_t1_dout", D_out, 8'h3C);
        tick();
        check("wr2_t2_flags", flags(), F_WR_T2);
        tick();
        check("wr2_t3_flags", flags(), F_WR_T3);
        check("wr2_t3_dout", D_out, 8'h3C);
        tick();
        check("wr_end_flags", flags(), F_IDLE);
        check("wr_end_xpt", XPT, 5'd4);

        // Priority m1 > rd > wr
        req_m1 = 1'b1; req_rd = 1'b1; req_wr = 1'b1;
        addr_in = 16'h0100; wdata_in = 8'h77; D_in = 8'h11;
        tick(); req_m1 = 1'b0;
        check("pri_m1_flags", flags(), F_M1_AB);
        tick();
        tick();
        check("pri_m1_refresh_a", A, 16'h0001);
        tick();
        check("pri_m1_t4_flags", flags(), F_M1_T4);
        tick(); req_rd = 1'b0;
        check("pri_rd_flags", flags(), F_RD);
        tick();
        tick();
        check("pri_rd_t3_flags", flags(), F_RD_T3);
        tick(); req_wr = 1'b0;
        check("pri_wr_flags", flags(), F_WR_T1);
        check("pri_wr_dout", D_out, 8'h77);
        tick();
        tick();
        tick();
        check("pri_end_flags", flags(), F_IDLE);
        check("pri_end_xpt", XPT, 5'd7);
        check("pri_rd_data", rd_data, 8'h11);

        // Phase-counter clear coincident with done
        req_rd = 1'b1;
        tick(); req_rd = 1'b0;
        tick();
        tick();
        check("clr_t3_flags", flags(), F_RD_T3);
        PR_Reset_XPT = 1'b1;
        tick(); PR_Reset_XPT = 1'b0;
        check("clr_xpt", XPT, 5'd0);

        // Saturation over 40 back-to-back reads
        req_rd = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (i == 91) check("sat_xpt_30", XPT, 5'd30);
        end
        req_rd = 1'b0;
        check("sat_xpt", XPT, 5'd31);
        check("sat_notxpt", notXPT, 5'd0);
        tick();
        check("sat_hold_xpt", XPT, 5'd31);
        check("sat_idle_flags", flags(), F_IDLE);

        // Asynchronous reset in the middle of a read
        req_rd = 1'b1; addr_in = 16'h4321;
        tick(); req_rd = 1'b0;
        tick();
        check("arst_t2_a", A, 16'h4321);
        #2;
        notRESET = 1'b0;
        #1;
        check("arst_flags", flags(), F_IDLE);
        check("arst_a", A, 16'h0000);
        check("arst_xpt", XPT, 5'd0);
        check("arst_notxpt", notXPT, 5'h1f);
        check("arst_rd_data", rd_data, 8'h00);
        #2;
        notRESET = 1'b1;
        tick();
        check("arst_post1_flags", flags(), F_IDLE);
        tick();
        check("arst_post2_flags", flags(), F_IDLE);
        check("arst_post_xpt", XPT, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/op_bus_cycle.md
Name: op_bus_cycle

Overview:
- Executes the CPU machine cycles that the opcode decoders request: M1 opcode fetch, memory read and memory write.
- Emits Z80-style bus strobes and returns the fetched or read byte.
- Owns the per-instruction phase counter, XPT/notXPT, which feeds every DECODER_op_* block.
- Decoder-side bus requests (read/write, address/data select) are merged upstream into the req_* / addr_in / wdata_in ports of this block.

Parameters:
- XPT_W, 5, width of phase counter XPT/notXPT
- R_W, 7, width of refresh counter

Ports:
- CLK  in  1  system clock
- notRESET  in  1  asynchronous active-low reset
- req_m1  in  1  start opcode-fetch cycle (level, sampled when accepting)
- req_rd  in  1  start memory-read cycle
- req_wr  in  1  start memory-write cycle
- addr_in  in  16  cycle address, captured at accept
- wdata_in  in  8  write data, captured at accept
- PR_Reset_XPT  in  1  clear phase counter
- notWAIT  in  1  bus wait, active low
- D_in  in  8  bus read data
- A  out  16  bus address
- D_out  out  8  bus write data
- D_oe  out  1  write-data output enable
- notM1, notMREQ, notRD, notWR, notRFSH  out  1 each  bus strobes, active low
- busy  out  1  cycle in progress
- done  out  1  one-cycle pulse on final T-state of a cycle
- rd_data  out  8  last fetched/read byte
- XPT  out  5  phase counter
- notXPT  out  5  bitwise inverse of XPT

Behaviour:
- Reset is asynchronous:
  - state=IDLE; A=0, D_out=0, D_oe=0; all strobes=1.
  - busy=0, done=0, rd_data=0, XPT=0, notXPT=5'b11111, R=0.
  - Reset mid-cycle aborts immediately; no done pulse is produced.
- States: IDLE, T1, T2, TW, T3, T4.
- Accept rule:
  - A request is accepted on an edge where state is IDLE, or where done=1 (back-to-back; next state T1, no idle gap).
  - Priority is m1 > rd > wr. Lower-priority requests stay pending.
  - addr_in, wdata_in and the cycle kind are captured at accept.
- Transitions:
  - T1→T2.
  - T2→TW if notWAIT=0, else →T3. TW stays while notWAIT=0, else →T3.
  - M1 cycles: T3→T4, T4→IDLE or T1.
  - Rd/wr cycles: T3→IDLE or T1.
- M1 cycle:
  - notM1=0 in T1–TW.
  - notMREQ=0 and notRD=0 in T1–TW.
  - rd_data<=D_in on the edge leaving T2/TW.
  - In T3–T4: A={8'h00,1'b0,R}, notRFSH=0, notMREQ=0 in T3 only.
  - R<=R+1 (wrap at 127→0) at the end of T4.
  - done=1 in T4. Length is 4 clocks plus waits.
- Read cycle:
  - notMREQ=0 and notRD=0 in T1–T3.
  - rd_data<=D_in on the edge leaving T3.
  - done=1 in T3. Length is 3 clocks plus waits.
- Write cycle:
  - notMREQ=0 in T1–T3; D_oe=1 in T1–T3; notWR=0 in T2–T3 (including TW).
  - D_out=captured data.
  - done=1 in T3.
- A holds the captured address T1 through the last T-state of rd/wr cycles, and T1–TW of M1 cycles.
- All outputs are registered (strobes change on CLK edges only). busy=1 in every state except IDLE.
- XPT:
  - If PR_Reset_XPT=1, XPT<=0 on that edge; this takes priority over increment.
  - Otherwise, if done=1, XPT<=XPT+1, saturating at 31.
  - notXPT is always ~XPT.
- A request arriving while busy and not done is held, not dropped: it is serviced when accepted.

Decomposition:
- Shared package holds:
  - state encodings (IDLE..T4);
  - cycle-kind codes (KIND_M1, KIND_RD, KIND_WR);
  - XPT_MAX=31.
- One natural sub-module: op_bus_xpt_counter (phase counter with reset/increment/saturate, driving XPT/notXPT).

Test Plan:
- Reset sequencing:
  - Reset mid-cycle: req_rd, then notRESET low during T2 → all strobes return to 1 and A=0 asynchronously.
  - XPT=0, no done pulse; after release, state=IDLE.
- M1 fetch, no wait:
  - req_m1 with addr_in=16'h1234, D_in=8'hDD.
  - Response: notM1/notMREQ/notRD low 2 clocks, rd_data=8'hDD, refresh A=16'h0000 with R=0, R=1 after done.
  - done in clock 4, XPT 0→1.
- Read with 2 wait states:
  - req_rd, addr=16'hFFFE, notWAIT=0 for 2 edges at T2, D_in=8'h5A.
  - Response: 5-clock cycle, rd_data=8'h5A, done once.
- Back-to-back write:
  - req_wr addr=16'h8000 data=8'hA5, then req_wr addr=16'h8001 data=8'h3C held.
  - Response: second T1 immediately follows first T3; notWR low T2–T3 each cycle; D_out correct per cycle; XPT+2.
- Request priority:
  - req_m1, req_rd and req_wr asserted together → M1 first, rd second, wr third.
- Phase counter:
  - PR_Reset_XPT coincident with done → XPT=0.
  - 40 consecutive cycles without reset → XPT saturates at 31, notXPT=0.
